iic_req_arbiter: RTL and testbench

- Shares the single IIC byte master between NUM_REQ register-access clients, for example the ADXL345 sensor controller plus further sensor and config controllers.
- Each client uses the same level-held request / ack-pulse protocol it would use on the master directly.
- The arbiter grants clients round-robin, forwards one transaction at a time, and returns ack/data to the winner.
- It aborts a transaction with an error pulse if the master hangs.

---
 rtl/iic_req_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_iic_req_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : iic_req_arbiter
// Purpose : Round-robin arbiter sharing one IIC byte master between NUM_REQ
//           register-access clients. Forwards one transaction at a time,
//           returns ack/data to the winner, and aborts a transaction with an
//           error pulse when the master never acknowledges.
// Rev     : 1.0  initial release
// ============================================================================
module iic_req_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 200000,
  parameter int TO_W    = 18,
  parameter int HOLDOFF = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     i_req_wr,
  input  logic [NUM_REQ-1:0]     i_req_rd,
  input  logic [8*NUM_REQ-1:0]   i_req_addr,
  input  logic [8*NUM_REQ-1:0]   i_req_wrdb,
  output logic [NUM_REQ-1:0]     o_req_ack,
  output logic [NUM_REQ-1:0]     o_req_err,
  output logic [7:0]             o_req_rddb,
  output logic [NUM_REQ-1:0]     o_gnt,
  output logic                   o_busy,
  output logic                   o_iicwr_req,
  output logic                   o_iicrd_req,
  output logic [7:0]             o_iic_addr,
  output logic [7:0]             o_iic_wrdb,
  input  logic [7:0]             i_iic_rddb,
  input  logic                   i_iic_ack
);

  localparam int c_IDX_W = $clog2(NUM_REQ);
  localparam int c_HO_W  = $clog2(HOLDOFF + 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_REQ - 1);
  localparam logic [TO_W-1:0]    c_TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [c_HO_W-1:0]  c_HO_LAST  = c_HO_W'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
  logic                 r_wr, w_wr_nxt;
  logic                 r_rd, w_rd_nxt;
  logic [7:0]           r_addr, w_addr_nxt;
  logic [7:0]           r_wrdb, w_wrdb_nxt;
  logic [c_IDX_W-1:0]   r_ptr, w_ptr_nxt;
  logic [c_IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [TO_W-1:0]      r_to_cnt, w_to_nxt;
  logic [c_HO_W-1:0]    r_ho_cnt, w_ho_nxt;

  logic [NUM_REQ-1:0]   w_pend;
  logic                 w_found;
  logic [c_IDX_W-1:0]   w_sel;
  logic [7:0]           w_addr_arr [NUM_REQ];
  logic [7:0]           w_wrdb_arr [NUM_REQ];

  assign w_pend = i_req_wr | i_req_rd;

  // Split the flat per-client buses into byte lanes
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
    assign w_addr_arr[k] = i_req_addr[8*k +: 8];
    assign w_wrdb_arr[k] = i_req_wrdb[8*k +: 8];
  end

  // Round-robin search: first pending client starting at r_ptr, wrapping
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int c;
      c = int'(r_ptr) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!w_found && w_pend[c[c_IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = c[c_IDX_W-1:0];
      end
    end
  end

  // Next-state, captured transaction and per-client ack/err pulses
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_wr_nxt    = r_wr;
    w_rd_nxt    = r_rd;
    w_addr_nxt  = r_addr;
    w_wrdb_nxt  = r_wrdb;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    w_to_nxt    = r_to_cnt;
    w_ho_nxt    = r_ho_cnt;
    o_req_ack   = '0;
    o_req_err   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = NUM_REQ'(1) << w_sel;
          // A client asserting both strobes gets a write
          w_wr_nxt    = i_req_wr[w_sel];
          w_rd_nxt    = i_req_rd[w_sel] & ~i_req_wr[w_sel];
          w_addr_nxt  = w_addr_arr[w_sel];
          w_wrdb_nxt  = w_wrdb_arr[w_sel];
          w_idx_nxt   = w_sel;
          w_to_nxt    = '0;
        end
      end
      S_GRANT: begin
        if (i_iic_ack || (r_to_cnt == c_TO_LAST)) begin
          // Ack has priority over a timeout landing in the same cycle
          if (i_iic_ack) o_req_ack = r_gnt;
          else           o_req_err = r_gnt;
          w_state_nxt = S_HOLD;
          w_gnt_nxt   = '0;
          w_wr_nxt    = 1'b0;
          w_rd_nxt    = 1'b0;
          w_addr_nxt  = '0;
          w_wrdb_nxt  = '0;
          w_ptr_nxt   = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
          w_to_nxt    = '0;
          w_ho_nxt    = '0;
        end else begin
          w_to_nxt = r_to_cnt + 1'b1;
        end
      end
      S_HOLD: begin
        // Let the finished client retract its request before re-arbitrating
        if (r_ho_cnt == c_HO_LAST) begin
          w_state_nxt = S_IDLE;
          w_ho_nxt    = '0;
        end else begin
          w_ho_nxt = r_ho_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops the master request at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_addr   <= '0;
      r_wrdb   <= '0;
      r_ptr    <= '0;
      r_idx    <= '0;
      r_to_cnt <= '0;
      r_ho_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_wr     <= w_wr_nxt;
      r_rd     <= w_rd_nxt;
      r_addr   <= w_addr_nxt;
      r_wrdb   <= w_wrdb_nxt;
      r_ptr    <= w_ptr_nxt;
      r_idx    <= w_idx_nxt;
      r_to_cnt <= w_to_nxt;
      r_ho_cnt <= w_ho_nxt;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_busy      = (r_state != S_IDLE);
  assign o_iicwr_req = r_wr;
  assign o_iicrd_req = r_rd;
  assign o_iic_addr  = r_addr;
  assign o_iic_wrdb  = r_wrdb;
  // Read data is a plain broadcast; clients qualify it with their ack
  assign o_req_rddb  = i_iic_rddb;

endmodule
`default_nettype wire

// File: tb/tb_iic_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_iic_req_arbiter
// Purpose : Self-checking bench for iic_req_arbiter with a scoreboard of
//           expected master transactions.
// Rev     : 1.0  initial release
// ============================================================================
module tb_iic_req_arbiter;
  localparam int NR  = 3;
  localparam int TO  = 20;
  localparam int TOW = 5;
  localparam int HO  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_wr, req_rd;
  logic [8*NR-1:0] req_addr, req_wrdb;
  logic [NR-1:0] req_ack, req_err, gnt;
  logic [7:0]    req_rddb, iic_addr, iic_wrdb, iic_rddb;
  logic          busy, iicwr_req, iicrd_req, iic_ack;

  iic_req_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO), .TO_W(TOW), .HOLDOFF(HO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_wr(req_wr), .i_req_rd(req_rd), .i_req_addr(req_addr), .i_req_wrdb(req_wrdb),
    .o_req_ack(req_ack), .o_req_err(req_err), .o_req_rddb(req_rddb), .o_gnt(gnt),
    .o_busy(busy), .o_iicwr_req(iicwr_req), .o_iicrd_req(iicrd_req),
    .o_iic_addr(iic_addr), .o_iic_wrdb(iic_wrdb), .i_iic_rddb(iic_rddb), .i_iic_ack(iic_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         client;
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] wrdb;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   ok;
  int   n;

  // Inputs change at posedge+1, outputs are sampled at posedge+2
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    tick();
    #1;
  endtask

  task automatic clear_inputs();
    req_wr = '0; req_rd = '0; req_addr = '0; req_wrdb = '0;
    iic_ack = 1'b0; iic_rddb = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  // Wait for a master request; n = cycles waited
  task automatic wait_mreq(input int budget, output bit found, output int waited);
    found = 1'b0;
    waited = 0;
    while (waited <= budget) begin
      if (iicwr_req || iicrd_req) begin
        found = 1'b1;
        break;
      end
      step();
      waited++;
    end
  endtask

  function automatic exp_t pop_exp();
    exp_t x;
    x.client = -1; x.wr = 1'b0; x.rd = 1'b0; x.addr = '0; x.wrdb = '0;
    if (sb.size() > 0) x = sb.pop_front();
    return x;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    req_wr = 3'b111; req_rd = 3'b111; req_addr = 24'hFFFFFF; iic_ack = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if ({gnt, busy, iicwr_req, iicrd_req} !== 6'b0) $display("FAIL reset_ctrl: got %b want 000000", {gnt, busy, iicwr_req, iicrd_req}); else n_pass++;
    n_checks++; if ({iic_addr, iic_wrdb} !== 16'h0) $display("FAIL reset_data: got %h want 0000", {iic_addr, iic_wrdb}); else n_pass++;
    n_checks++; if ({req_ack, req_err} !== 6'b0) $display("FAIL reset_ackerr: got %b want 000000", {req_ack, req_err}); else n_pass++;
    tick();
    clear_inputs();
    iic_ack = 1'b1;
    rst_n = 1'b1;
    #1;
    n_checks++; if (req_ack !== 3'b000) $display("FAIL stale_ack_idle: got %b want 000", req_ack); else n_pass++;
    tick();
    iic_ack = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single_read();
    do_reset();
    tick();
    req_rd[0] = 1'b1; req_addr[7:0] = 8'h32;
    sb.push_back('{0, 1'b0, 1'b1, 8'h32, 8'h00});
    #1;
    n_checks++; if (iicrd_req !== 1'b0) $display("FAIL rd_latency_early: got %b want 0", iicrd_req); else n_pass++;
    step();
    e = pop_exp();
    n_checks++; if ({gnt, iicwr_req, iicrd_req, iic_addr, iic_wrdb} !== {3'(1 << e.client), e.wr, e.rd, e.addr, e.wrdb})
      $display("FAIL rd_request: got %h want %h", {gnt, iicwr_req, iicrd_req, iic_addr, iic_wrdb}, {3'(1 << e.client), e.wr, e.rd, e.addr, e.wrdb}); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL rd_busy: got %b want 1", busy); else n_pass++;
    repeat (4) step();
    tick();
    iic_ack = 1'b1; iic_rddb = 8'hA5;
    #1;
    n_checks++; if (req_ack !== 3'b001) $display("FAIL rd_ack: got %b want 001", req_ack); else n_pass++;
    n_checks++; if (req_rddb !== 8'hA5) $display("FAIL rd_data: got %h want a5", req_rddb); else n_pass++;
    n_checks++; if (req_err !== 3'b000) $display("FAIL rd_noerr: got %b want 000", req_err); else n_pass++;
    tick();
    iic_ack = 1'b0;
    #1;
    n_checks++; if ({iicrd_req, gnt, req_ack} !== 7'b0) $display("FAIL rd_release: got %b want 0000000", {iicrd_req, gnt, req_ack}); else n_pass++;
    step();
    tick();
    req_rd[0] = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({iicwr_req, iicrd_req} !== 2'b00) $display("FAIL rd_no_dup: got %b want 00", {iicwr_req, iicrd_req}); else n_pass++;
      step();
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    tick();
    req_wr = 3'b111;
    req_addr = {8'h22, 8'h21, 8'h20};
    req_wrdb = {8'hC2, 8'hC1, 8'hC0};
    for (int k = 0; k < 6; k++)
      sb.push_back('{k % 3, 1'b1, 1'b0, 8'(8'h20 + k % 3), 8'(8'hC0 + k % 3)});
    #1;
    for (int t = 0; t < 6; t++) begin
      wait_mreq(10, ok, n);
      n_checks++; if (!ok) $display("FAIL rr_wait: got no request want request within 10 cycles"); else n_pass++;
      // Idle gap = HOLD cycles plus the IDLE sampling cycle
      if (t > 0) begin
        n_checks++; if (n !== HO + 1) $display("FAIL rr_gap: got %0d want %0d", n, HO + 1); else n_pass++;
      end
      e = pop_exp();
      n_checks++; if ({gnt, iicwr_req, iicrd_req, iic_addr, iic_wrdb} !== {3'(1 << e.client), e.wr, e.rd, e.addr, e.wrdb})
        $display("FAIL rr_grant: got %h want %h", {gnt, iicwr_req, iicrd_req, iic_addr, iic_wrdb}, {3'(1 << e.client), e.wr, e.rd, e.addr, e.wrdb}); else n_pass++;
      repeat (2) begin
        step();
        n_checks++; if ($countones(gnt) != 1) $display("FAIL rr_onehot: got %b want one-hot", gnt); else n_pass++;
      end
      tick();
      iic_ack = 1'b1;
      #1;
      n_checks++; if (req_ack !== 3'(1 << e.client)) $display("FAIL rr_ack: got %b want %b", req_ack, 3'(1 << e.client)); else n_pass++;
      tick();
      iic_ack = 1'b0;
      if (t == 5) req_wr = '0;
      #1;
      n_checks++; if ({gnt, busy} !== 4'b0001) $display("FAIL rr_hold: got %b want 0001", {gnt, busy}); else n_pass++;
    end
  endtask

  task automatic test_write_priority();
    do_reset();
    tick();
    req_wr[1] = 1'b1; req_rd[1] = 1'b1; req_addr[15:8] = 8'h31; req_wrdb[15:8] = 8'h0B;
    sb.push_back('{1, 1'b1, 1'b0, 8'h31, 8'h0B});
    #1;
    wait_mreq(5, ok, n);
    n_checks++; if (!ok) $display("FAIL wp_wait: got no request want request within 5 cycles"); else n_pass++;
    e = pop_exp();
    n_checks++; if ({gnt, iicwr_req, iicrd_req, iic_addr, iic_wrdb} !== {3'(1 << e.client), e.wr, e.rd, e.addr, e.wrdb})
      $display("FAIL wp_request: got %h want %h", {gnt, iicwr_req, iicrd_req, iic_addr, iic_wrdb}, {3'(1 << e.client), e.wr, e.rd, e.addr, e.wrdb}); else n_pass++;
    tick();
    iic_ack = 1'b1;
    #1;
    n_checks++; if (req_ack !== 3'b010) $display("FAIL wp_ack: got %b want 010", req_ack); else n_pass++;
    tick();
    iic_ack = 1'b0; req_wr = '0; req_rd = '0;
    #1;
  endtask

  task automatic test_timeout();
    do_reset();
    tick();
    req_rd[2] = 1'b1; req_addr[23:16] = 8'h53;
    sb.push_back('{2, 1'b0, 1'b1, 8'h53, 8'h00});
    #1;
    wait_mreq(5, ok, n);
    n_checks++; if (!ok) $display("FAIL to_wait: got no request want request within 5 cycles"); else n_pass++;
    e = pop_exp();
    n_checks++; if ({gnt, iicrd_req, iic_addr} !== {3'(1 << e.client), e.rd, e.addr}) $display("FAIL to_grant: got %h want %h", {gnt, iicrd_req, iic_addr}, {3'(1 << e.client), e.rd, e.addr}); else n_pass++;
    req_rd[0] = 1'b1; req_addr[7:0] = 8'h10;
    sb.push_back('{0, 1'b0, 1'b1, 8'h10, 8'h00});
    n_checks++; if (req_err !== 3'b000) $display("FAIL to_early_err: got %b want 000 at cycle 1", req_err); else n_pass++;
    for (int c = 2; c < TO; c++) begin
      step();
      n_checks++; if (req_err !== 3'b000) $display("FAIL to_early_err: got %b want 000 at cycle %0d", req_err, c); else n_pass++;
    end
    step();
    n_checks++; if ({req_err, req_ack} !== 6'b100000) $display("FAIL to_err: got %b want 100000", {req_err, req_ack}); else n_pass++;
    tick();
    req_rd[2] = 1'b0;
    #1;
    n_checks++; if ({iicwr_req, iicrd_req, gnt, req_err} !== 8'b0) $display("FAIL to_release: got %b want 00000000", {iicwr_req, iicrd_req, gnt, req_err}); else n_pass++;
    wait_mreq(10, ok, n);
    n_checks++; if (!ok) $display("FAIL to_next_wait: got no request want request within 10 cycles"); else n_pass++;
    e = pop_exp();
    n_checks++; if ({gnt, iicrd_req, iic_addr} !== {3'(1 << e.client), e.rd, e.addr}) $display("FAIL to_next_grant: got %h want %h", {gnt, iicrd_req, iic_addr}, {3'(1 << e.client), e.rd, e.addr}); else n_pass++;
    tick();
    iic_ack = 1'b1;
    #1;
    n_checks++; if (req_ack !== 3'b001) $display("FAIL to_next_ack: got %b want 001", req_ack); else n_pass++;
    tick();
    iic_ack = 1'b0; req_rd = '0;
    #1;
  endtask

  task automatic test_collision();
    do_reset();
    tick();
    req_rd[1] = 1'b1; req_addr[15:8] = 8'h44;
    #1;
    wait_mreq(5, ok, n);
    n_checks++; if (!ok) $display("FAIL col_wait: got no request want request within 5 cycles"); else n_pass++;
    for (int c = 2; c < TO; c++) step();
    tick();
    iic_ack = 1'b1; iic_rddb = 8'h5C;
    #1;
    n_checks++; if ({req_ack, req_err} !== 6'b010000) $display("FAIL col_ack_err: got %b want 010000", {req_ack, req_err}); else n_pass++;
    n_checks++; if (req_rddb !== 8'h5C) $display("FAIL col_data: got %h want 5c", req_rddb); else n_pass++;
    tick();
    iic_ack = 1'b0; req_rd = '0;
    #1;
    n_checks++; if ({req_err, iicrd_req} !== 4'b0) $display("FAIL col_after: got %b want 0000", {req_err, iicrd_req}); else n_pass++;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    tick();
    req_rd[0] = 1'b1; req_addr = {8'h00, 8'h61, 8'h60};
    sb.push_back('{0, 1'b0, 1'b1, 8'h60, 8'h00});
    #1;
    wait_mreq(5, ok, n);
    e = pop_exp();
    n_checks++; if (gnt !== 3'(1 << e.client)) $display("FAIL rm_first: got %b want %b", gnt, 3'(1 << e.client)); else n_pass++;
    tick();
    iic_ack = 1'b1;
    #1;
    tick();
    iic_ack = 1'b0; req_rd[0] = 1'b0;
    #1;
    tick();
    req_rd = 3'b011;
    sb.push_back('{1, 1'b0, 1'b1, 8'h61, 8'h00});
    #1;
    wait_mreq(10, ok, n);
    e = pop_exp();
    n_checks++; if ({gnt, iicrd_req, iic_addr} !== {3'(1 << e.client), e.rd, e.addr}) $display("FAIL rm_second: got %h want %h", {gnt, iicrd_req, iic_addr}, {3'(1 << e.client), e.rd, e.addr}); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({gnt, busy, iicwr_req, iicrd_req, iic_addr} !== 14'b0) $display("FAIL rm_async: got %h want 0000", {gnt, busy, iicwr_req, iicrd_req, iic_addr}); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.push_back('{0, 1'b0, 1'b1, 8'h60, 8'h00});
    #1;
    wait_mreq(5, ok, n);
    n_checks++; if (!ok) $display("FAIL rm_restart_wait: got no request want request within 5 cycles"); else n_pass++;
    e = pop_exp();
    n_checks++; if ({gnt, iicrd_req, iic_addr} !== {3'(1 << e.client), e.rd, e.addr}) $display("FAIL rm_restart: got %h want %h", {gnt, iicrd_req, iic_addr}, {3'(1 << e.client), e.rd, e.addr}); else n_pass++;
    tick();
    iic_ack = 1'b1;
    #1;
    tick();
    iic_ack = 1'b0; req_rd = '0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_priority();
    test_timeout();
    test_collision();
    test_reset_mid_grant();
    n_checks++; if (sb.size() != 0) $display("FAIL sb_drain: got %0d left want 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish before 1 ms");
    $fatal(1);
  end

endmodule
`default_nettype wire
